// File: rtl/fp_mul_arbiter_if.sv
// Bus between the FP multiply arbiter, its requesters and the shared multiplier.
//   req/req_a/req_b       : requester levels and packed FP32 operands (32 bits per requester)
//   ack/res/res_overflow  : one-hot completion pulse, product and overflow flag
//   grant_id/busy         : index being served, arbiter occupied
//   mul_in1/mul_in2/mul_enable/mul_out/mul_overflow : shared multiplier port
// The slave modport is the arbiter's view; master is the environment's view.
interface fp_mul_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    ack;
    logic [31:0]           res;
    logic                  res_overflow;
    logic [IDX_W-1:0]      grant_id;
    logic                  busy;
    logic [31:0]           mul_in1;
    logic [31:0]           mul_in2;
    logic                  mul_enable;
    logic [31:0]           mul_out;
    logic                  mul_overflow;

    modport slave (
        input  req, req_a, req_b, mul_out, mul_overflow,
        output ack, res, res_overflow, grant_id, busy, mul_in1, mul_in2, mul_enable
    );

    modport master (
        output req, req_a, req_b, mul_out, mul_overflow,
        input  ack, res, res_overflow, grant_id, busy, mul_in1, mul_in2, mul_enable
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP32 multiplier between NUM_REQ requesters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : fp_mul_arbiter_if.slave (requester side and multiplier side)
// A grant latches the winner's operands, holds mul_enable for MUL_LATENCY
// cycles, captures the product and returns it with a one-cycle one-hot ack.
module fp_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic           clk,
    input  logic           reset,
    fp_mul_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [31:0]        res_q, res_d;
    logic               res_ovf_q, res_ovf_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [31:0]        mul_in1_q, mul_in1_d;
    logic [31:0]        mul_in2_q, mul_in2_d;
    logic               mul_en_q, mul_en_d;

    logic [31:0]        op_a [NUM_REQ];
    logic [31:0]        op_b [NUM_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // Unpack the flat operand buses into per-requester words.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = bus.req_a[g*32 +: 32];
        assign op_b[g] = bus.req_b[g*32 +: 32];
    end

    // First pending request at or above rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        int unsigned sum;
        logic [IDX_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        mul_in1_d = mul_in1_q;
        mul_in2_d = mul_in2_q;
        mul_en_d  = mul_en_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d   = win_idx;
                    mul_in1_d = op_a[win_idx];
                    mul_in2_d = op_b[win_idx];
                    cnt_d     = '0;
                    mul_en_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(MUL_LATENCY - 1)) begin
                    res_d     = bus.mul_out;
                    res_ovf_d = bus.mul_overflow;
                    ack_d     = NUM_REQ'(1) << grant_q;
                    mul_en_d  = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ack_d    = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            mul_in1_q <= '0;
            mul_in2_q <= '0;
            mul_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            mul_in1_q <= mul_in1_d;
            mul_in2_q <= mul_in2_d;
            mul_en_q  <= mul_en_d;
        end
    end

    assign bus.ack          = ack_q;
    assign bus.res          = res_q;
    assign bus.res_overflow = res_ovf_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_q;
    assign bus.mul_in1      = mul_in1_q;
    assign bus.mul_in2      = mul_in2_q;
    assign bus.mul_enable   = mul_en_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural multiplier, reference arbitration
// model feeding an expectation queue, and a negedge monitor that checks it.
module tb_fp_mul_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned L       = 4;
    localparam int unsigned CNT_W   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_mul_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .MUL_LATENCY(L), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // FP32 multiply with truncation and wrapped exponent; returns {overflow, product}.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {(e > 254), a[31] ^ b[31], 8'(e), m};
    endfunction

    // Multiplier: result valid only in the last cycle of an L-cycle enable run.
    int unsigned en_cnt = 0;
    logic [32:0] prod;
    always @(posedge clk) en_cnt <= bus.mul_enable ? en_cnt + 1 : 0;
    always_comb prod = fmul(bus.mul_in1, bus.mul_in2);
    assign bus.mul_out      = (bus.mul_enable && en_cnt == L - 1) ? prod[31:0] : 32'hdeadbeef;
    assign bus.mul_overflow = (bus.mul_enable && en_cnt == L - 1) ? prod[32] : ~prod[32];

    // Reference arbitration model.
    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        ovf;
        int          due;
    } exp_t;
    exp_t        exp_q[$];
    int          cyc = 0;
    int          rem = 0;
    int          rr = 0;
    int          cur_idx = 0;
    logic [31:0] cur_a = '0, cur_b = '0, cur_res = '0, held_res = '0;
    logic        cur_ovf = 1'b0, held_ovf = 1'b0;
    bit          zero_chk = 1'b0;

    initial begin
        logic [32:0] r;
        int j;
        forever begin
            @(posedge clk);
            cyc++;
            zero_chk = 1'b0;
            if (reset) begin
                rem = 0; rr = 0; exp_q.delete();
                held_res = '0; held_ovf = 1'b0; zero_chk = 1'b1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 1) begin
                    held_res = cur_res;
                    held_ovf = cur_ovf;
                end
                if (rem == 0) rr = (cur_idx + 1) % NUM_REQ;
            end else if (bus.req != '0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    j = (rr + k) % NUM_REQ;
                    if (((bus.req >> j) & NUM_REQ'(1)) != '0) cur_idx = j;
                end
                cur_a   = 32'(bus.req_a >> (32 * cur_idx));
                cur_b   = 32'(bus.req_b >> (32 * cur_idx));
                r       = fmul(cur_a, cur_b);
                cur_res = r[31:0];
                cur_ovf = r[32];
                exp_q.push_back('{cur_idx, cur_res, cur_ovf, cyc + L});
                rem = L + 1;
            end
        end
    end

    // Monitor: compares DUT outputs against the model every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc == 0) continue;
            if (zero_chk) begin
                chk("reset_ctl", 128'({bus.ack, bus.res_overflow, bus.grant_id, bus.busy, bus.mul_enable}), '0);
                chk("reset_res", 128'(bus.res), '0);
                chk("reset_mul_in", 128'({bus.mul_in1, bus.mul_in2}), '0);
            end else begin
                chk("mul_enable", 128'(bus.mul_enable), 128'(rem >= 2));
                chk("busy", 128'(bus.busy), 128'(rem >= 1));
                if (rem >= 1) chk("grant_id", 128'(bus.grant_id), 128'(cur_idx));
                if (rem >= 2) chk("mul_in", 128'({bus.mul_in1, bus.mul_in2}), 128'({cur_a, cur_b}));
                if (bus.ack != '0 || (exp_q.size() > 0 && exp_q[0].due == cyc)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 128'(bus.ack), '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_onehot", 128'(bus.ack), 128'(NUM_REQ'(1) << e.idx));
                        chk("ack_time", 128'(cyc), 128'(e.due));
                        chk("res", 128'(bus.res), 128'(e.res));
                        chk("res_overflow", 128'(bus.res_overflow), 128'(e.ovf));
                    end
                end else begin
                    chk("res_hold", 128'({bus.res_overflow, bus.res}), 128'({held_ovf, held_res}));
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    // Wait for any ack; returns winner index and negedges waited.
    task automatic wait_any(output int idx, output int n);
        idx = -1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == '0 && n < 40);
        if (bus.ack == '0) begin
            tests++; fails++;
            $display("FAIL ack_timeout: actual no ack required ack within 40 cycles");
        end else begin
            for (int k = 0; k < NUM_REQ; k++) if (bus.ack[k]) idx = k;
            bus.req[idx] = 1'b0;
        end
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!bus.mul_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mul_enable) begin
            tests++; fails++;
            $display("FAIL enable_timeout: actual mul_enable 0 required 1");
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        int idx, n;
        reset = 1'b1;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single request: latency and known product.
        set_op(0, 32'h40aa6666, 32'h40aa6666);
        bus.req[0] = 1'b1;
        wait_any(idx, n);
        chk("single_idx", 128'(idx), 128'(0));
        chk("single_latency", 128'(n), 128'(L + 1));
        chk("single_res", 128'({bus.res_overflow, bus.res}), 128'({1'b0, 32'h41e2d850}));
        repeat (2) @(negedge clk);

        // Contention from a fresh pointer: order 0,1,2,3.
        pulse_reset();
        set_op(0, 32'h3f800000, 32'h40000000);
        set_op(1, 32'hc0080000, 32'hc0680000);
        set_op(2, 32'h40400000, 32'hbf000000);
        set_op(3, 32'h3fc00000, 32'h40400000);
        bus.req = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            wait_any(idx, n);
            chk("contention_order", 128'(idx), 128'(k));
            if (idx == 1) chk("contention_r1_res", 128'(bus.res), 128'(32'h40f68000));
        end
        repeat (2) @(negedge clk);

        // Overflow on requester 2, then wrap: 3 before 0.
        set_op(2, 32'h7f000000, 32'h7f000000);
        bus.req[2] = 1'b1;
        wait_any(idx, n);
        chk("ovf_idx", 128'(idx), 128'(2));
        chk("ovf_res", 128'({bus.res_overflow, bus.res}), 128'({1'b1, 32'h3e800000}));
        bus.req[0] = 1'b1;
        bus.req[3] = 1'b1;
        wait_any(idx, n);
        chk("wrap_first", 128'(idx), 128'(3));
        wait_any(idx, n);
        chk("wrap_second", 128'(idx), 128'(0));
        repeat (2) @(negedge clk);

        // Reset in the second RUN cycle, then restart from grant.
        set_op(1, 32'h3fc00000, 32'h40400000);
        bus.req[1] = 1'b1;
        wait_enable();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", 128'({bus.ack, bus.mul_enable, bus.busy}), '0);
        reset = 1'b0;
        wait_any(idx, n);
        chk("rst_restart_idx", 128'(idx), 128'(1));
        chk("rst_restart_latency", 128'(n), 128'(L + 1));
        chk("rst_restart_res", 128'(bus.res), 128'(32'h40900000));
        repeat (2) @(negedge clk);

        // Operand change after grant is ignored.
        set_op(0, 32'h40400000, 32'h40400000);
        bus.req[0] = 1'b1;
        wait_enable();
        bus.req_a[31:0] = 32'h3f800000;
        @(negedge clk);
        chk("opchg_mul_in1", 128'(bus.mul_in1), 128'(32'h40400000));
        wait_any(idx, n);
        chk("opchg_res", 128'(bus.res), 128'(32'h41100000));
        repeat (2) @(negedge clk);

        // Random traffic; some requesters keep req high after ack.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.ack[i]) begin
                    bus.req[i] = ($urandom_range(3) == 0);
                end else if (!bus.req[i] && $urandom_range(2) == 0) begin
                    set_op(i, $urandom, $urandom);
                    bus.req[i] = 1'b1;
                end
            end
        end
        // Drain outstanding requests.
        for (int c = 0; c < 200 && (bus.req != '0 || rem != 0); c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("drain_pending", 128'(exp_q.size()), '0);
        chk("drain_req", 128'(bus.req), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog");
    end

endmodule
